// File: rtl/regincr_arb_pkg.sv
// Shared types and constants for the round-robin registered incrementer.
// Optional counter build switch: REGINCR_ARBITER_STATS_EN.
package regincr_arb_pkg;

  localparam int MSG_W    = 8;
  localparam int CNT_W    = 16;
  localparam int MAX_NREQ = 4;
  localparam int IDX_W    = $clog2(MAX_NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/regincr_arb_rr_picker.sv
// Combinational round-robin picker: first valid requester at or above ptr,
// wrapping modulo NREQ; returns a one-hot grant and its index.
module regincr_arb_rr_picker
  import regincr_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  req_val,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  localparam int SUM_W = IDX_W + 1;

  logic [MAX_NREQ-1:0] val_pad;
  logic [SUM_W-1:0]    sum;
  logic [IDX_W-1:0]    idx;
  logic                found;

  assign val_pad = MAX_NREQ'(req_val);

  always_comb begin
    sum     = '0;
    idx     = '0;
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + SUM_W'(k);
      if (sum >= SUM_W'(NREQ)) begin
        sum = sum - SUM_W'(NREQ);
      end
      idx = sum[IDX_W-1:0];
      if (!found && val_pad[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt[i] = found && (gnt_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/regincr_arbiter.sv
// NREQ requesters share one registered +INCR datapath (IDLE/CALC/RESP).
// Define REGINCR_ARBITER_STATS_EN to add the saturating xact_count port.
module regincr_arbiter
  import regincr_arb_pkg::*;
#(
  parameter int          NREQ = 2,
  parameter int unsigned INCR = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_val,
  output logic [NREQ-1:0]       req_rdy,
  input  logic [NREQ*MSG_W-1:0] req_msg,
  output logic [NREQ-1:0]       resp_val,
  input  logic [NREQ-1:0]       resp_rdy,
  output logic [MSG_W-1:0]      resp_msg,
  output logic                  busy
`ifdef REGINCR_ARBITER_STATS_EN
  ,
  output logic [CNT_W-1:0]      xact_count
`endif
);

  localparam logic [MSG_W-1:0] INCR_C = MSG_W'(INCR);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] id_q, id_d;
  logic [MSG_W-1:0] op_q, op_d;
  logic [MSG_W-1:0] res_q, res_d;

  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic [MSG_W-1:0] gnt_msg;
  logic             resp_fire;

  regincr_arb_rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req_val (req_val),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    gnt_msg = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_msg = req_msg[i*MSG_W +: MSG_W];
      end
    end
  end

  // Ready is forced low while reset is held, even though gnt is live.
  always_comb begin
    req_rdy = '0;
    if (reset && (state_q == IDLE)) begin
      req_rdy = gnt;
    end
  end

  always_comb begin
    resp_val = '0;
    for (int i = 0; i < NREQ; i++) begin
      resp_val[i] = (state_q == RESP) && (id_q == IDX_W'(i));
    end
  end

  assign resp_msg  = res_q;
  assign busy      = (state_q != IDLE);
  assign resp_fire = |(resp_val & resp_rdy);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_d    = op_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          op_d    = gnt_msg;
          id_d    = gnt_idx;
          state_d = CALC;
        end
      end
      CALC: begin
        res_d   = op_q + INCR_C;
        state_d = RESP;
      end
      RESP: begin
        if (resp_fire) begin
          if (id_q == IDX_W'(NREQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = id_q + 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

`ifdef REGINCR_ARBITER_STATS_EN
  logic [CNT_W-1:0] xact_q, xact_d;

  always_comb begin
    xact_d = xact_q;
    if (resp_fire && (xact_q != '1)) begin
      xact_d = xact_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xact_q <= '0;
    end else begin
      xact_q <= xact_d;
    end
  end

  assign xact_count = xact_q;
`endif

endmodule
